// File: rtl/stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller and its MDU latency counter.
package stall_ctrl_pkg;

    localparam int unsigned MDU_CNT_W = 4;

    localparam logic ST_RUN      = 1'b0;
    localparam logic ST_MDU_WAIT = 1'b1;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic if_id_flush;
        logic id_ex_en;
        logic id_ex_flush;
        logic ex_mem_en;
        logic ex_mem_flush;
        logic mem_wb_flush;
    } stage_ctrl_t;

endpackage

// File: rtl/mdu_lat_counter.sv
// Fixed-latency multiply/divide sequencer: tracks the busy window and pulses done on completion.
module mdu_lat_counter
    import stall_ctrl_pkg::*;
#(
    parameter int unsigned MDU_LAT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic hold_i,
    input  logic start_i,
    output logic stall_o,
    output logic done_o,
    output logic busy_o
);

    localparam logic [MDU_CNT_W-1:0] LOAD_VAL = MDU_CNT_W'(MDU_LAT - 1);

    logic                 state_q, state_d;
    logic [MDU_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_o  = 1'b0;
        // A data-memory stall freezes the sequencer, including the done pulse.
        if (!hold_i) begin
            if (state_q == ST_RUN) begin
                if (start_i) begin
                    state_d = ST_MDU_WAIT;
                    cnt_d   = LOAD_VAL;
                end
            end else if (cnt_q != '0) begin
                cnt_d = cnt_q - MDU_CNT_W'(1);
            end else begin
                done_o  = 1'b1;
                state_d = ST_RUN;
            end
        end
    end

    assign stall_o = ((state_q == ST_RUN) & start_i) |
                     ((state_q == ST_MDU_WAIT) & (cnt_q != '0));
    assign busy_o  = (state_q == ST_MDU_WAIT) | ((state_q == ST_RUN) & start_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline: prioritises hazards and slow-resource
// waits into per-stage enables/flushes and counts stalled cycles.
module pipe_stall_ctrl
    import stall_ctrl_pkg::*;
#(
    parameter int unsigned MDU_LAT = 4,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             imem_ready,
    input  logic             mem_req,
    input  logic             dmem_ready,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mdu_start,
    input  logic             ex_branch_taken,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_en,
    output logic             id_ex_flush,
    output logic             ex_mem_en,
    output logic             ex_mem_flush,
    output logic             mem_wb_flush,
    output logic             mdu_done,
    output logic             mdu_busy,
    output logic [CNT_W-1:0] stall_cnt
);

    logic        dmem_stall, load_use, imem_stall, mdu_stall;
    logic        mdu_done_raw, mdu_busy_raw;
    stage_ctrl_t ctrl;
    logic [CNT_W-1:0] stall_cnt_q;

    assign dmem_stall = mem_req & ~dmem_ready;
    assign imem_stall = ~imem_ready;
    assign load_use   = ex_mem_read & (ex_rt != REG_ZERO) &
                        ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));

    mdu_lat_counter #(
        .MDU_LAT (MDU_LAT)
    ) u_mdu (
        .clk     (clk),
        .rst_n   (rst_n),
        .hold_i  (dmem_stall),
        .start_i (ex_mdu_start),
        .stall_o (mdu_stall),
        .done_o  (mdu_done_raw),
        .busy_o  (mdu_busy_raw)
    );

    always_comb begin
        ctrl = '{pc_en: 1'b1, if_id_en: 1'b1, id_ex_en: 1'b1, ex_mem_en: 1'b1, default: 1'b0};
        if (!rst_n) begin
            ctrl = '{if_id_flush: 1'b1, id_ex_flush: 1'b1, ex_mem_flush: 1'b1,
                     mem_wb_flush: 1'b1, default: 1'b0};
        end else if (dmem_stall) begin
            // Freeze everything up to MEM; a pending branch redirects after release.
            ctrl.pc_en        = 1'b0;
            ctrl.if_id_en     = 1'b0;
            ctrl.id_ex_en     = 1'b0;
            ctrl.ex_mem_en    = 1'b0;
            ctrl.mem_wb_flush = 1'b1;
        end else if (mdu_stall) begin
            ctrl.pc_en        = 1'b0;
            ctrl.if_id_en     = 1'b0;
            ctrl.id_ex_en     = 1'b0;
            ctrl.ex_mem_flush = 1'b1;
        end else if (ex_branch_taken) begin
            ctrl.if_id_flush = 1'b1;
            ctrl.id_ex_flush = 1'b1;
        end else if (load_use) begin
            ctrl.pc_en       = 1'b0;
            ctrl.if_id_en    = 1'b0;
            ctrl.id_ex_flush = 1'b1;
        end else if (imem_stall) begin
            ctrl.pc_en       = 1'b0;
            ctrl.if_id_flush = 1'b1;
        end
    end

    assign pc_en        = ctrl.pc_en;
    assign if_id_en     = ctrl.if_id_en;
    assign if_id_flush  = ctrl.if_id_flush;
    assign id_ex_en     = ctrl.id_ex_en;
    assign id_ex_flush  = ctrl.id_ex_flush;
    assign ex_mem_en    = ctrl.ex_mem_en;
    assign ex_mem_flush = ctrl.ex_mem_flush;
    assign mem_wb_flush = ctrl.mem_wb_flush;
    assign mdu_done     = rst_n & mdu_done_raw;
    assign mdu_busy     = rst_n & mdu_busy_raw;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (!ctrl.pc_en && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: directed per-cycle vectors with hand-computed outputs.
module tb_pipe_stall_ctrl;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic if_id_flush;
        logic id_ex_en;
        logic id_ex_flush;
        logic ex_mem_en;
        logic ex_mem_flush;
        logic mem_wb_flush;
        logic mdu_done;
        logic mdu_busy;
    } outs_t;

    typedef struct packed {
        logic       imem_ready;
        logic       mem_req;
        logic       dmem_ready;
        logic       ex_mem_read;
        logic [4:0] ex_rt;
        logic [4:0] id_rs;
        logic [4:0] id_rt;
        logic       id_uses_rt;
        logic       ex_mdu_start;
        logic       ex_branch_taken;
    } in_t;

    typedef struct {
        string      tag;
        outs_t      o;
        logic [3:0] cnt;
    } sb_t;

    // Field order: pc_en if_id_en if_id_flush id_ex_en id_ex_flush ex_mem_en ex_mem_flush
    //              mem_wb_flush mdu_done mdu_busy
    localparam outs_t O_RUN   = 10'b1101010000;
    localparam outs_t O_LU    = 10'b0001110000;
    localparam outs_t O_MDU   = 10'b0000011001;
    localparam outs_t O_MDONE = 10'b1101010011;
    localparam outs_t O_DMEM  = 10'b0000000100;
    localparam outs_t O_DMEMB = 10'b0000000101;
    localparam outs_t O_BR    = 10'b1111110000;
    localparam outs_t O_IMEM  = 10'b0111010000;
    localparam outs_t O_RST   = 10'b0010101100;

    logic       clk, rst_n;
    logic       imem_ready, mem_req, dmem_ready, ex_mem_read, id_uses_rt;
    logic       ex_mdu_start, ex_branch_taken;
    logic [4:0] ex_rt, id_rs, id_rt;
    logic       pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
    logic       ex_mem_en, ex_mem_flush, mem_wb_flush, mdu_done, mdu_busy;
    logic [3:0] stall_cnt;
    outs_t      act;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [3:0] exp_cnt  = 4'd0;
    sb_t        sb_q[$];

    pipe_stall_ctrl #(
        .MDU_LAT (4),
        .CNT_W   (4)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_ready      (imem_ready),
        .mem_req         (mem_req),
        .dmem_ready      (dmem_ready),
        .ex_mem_read     (ex_mem_read),
        .ex_rt           (ex_rt),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rt      (id_uses_rt),
        .ex_mdu_start    (ex_mdu_start),
        .ex_branch_taken (ex_branch_taken),
        .pc_en           (pc_en),
        .if_id_en        (if_id_en),
        .if_id_flush     (if_id_flush),
        .id_ex_en        (id_ex_en),
        .id_ex_flush     (id_ex_flush),
        .ex_mem_en       (ex_mem_en),
        .ex_mem_flush    (ex_mem_flush),
        .mem_wb_flush    (mem_wb_flush),
        .mdu_done        (mdu_done),
        .mdu_busy        (mdu_busy),
        .stall_cnt       (stall_cnt)
    );

    assign act = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, ex_mem_flush,
                  mem_wb_flush, mdu_done, mdu_busy};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] got,
                                  input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0b required %0b", name, got, want);
        end
    endfunction

    function automatic in_t vin(input int imr, input int mreq, input int dmr, input int mrd,
                                input int ert, input int rs, input int rt, input int urt,
                                input int ms, input int br);
        in_t v;
        v.imem_ready      = 1'(imr);
        v.mem_req         = 1'(mreq);
        v.dmem_ready      = 1'(dmr);
        v.ex_mem_read     = 1'(mrd);
        v.ex_rt           = 5'(ert);
        v.id_rs           = 5'(rs);
        v.id_rt           = 5'(rt);
        v.id_uses_rt      = 1'(urt);
        v.ex_mdu_start    = 1'(ms);
        v.ex_branch_taken = 1'(br);
        return v;
    endfunction

    task automatic drive(input in_t v);
        imem_ready      = v.imem_ready;
        mem_req         = v.mem_req;
        dmem_ready      = v.dmem_ready;
        ex_mem_read     = v.ex_mem_read;
        ex_rt           = v.ex_rt;
        id_rs           = v.id_rs;
        id_rt           = v.id_rt;
        id_uses_rt      = v.id_uses_rt;
        ex_mdu_start    = v.ex_mdu_start;
        ex_branch_taken = v.ex_branch_taken;
    endtask

    // Drive one cycle of inputs and queue the outputs expected during that cycle.
    task automatic apply(input string tag, input in_t v, input outs_t e);
        sb_t s;
        drive(v);
        s.tag = tag;
        s.o   = e;
        s.cnt = exp_cnt;
        sb_q.push_back(s);
        if (!e.pc_en && exp_cnt != 4'hF) exp_cnt = exp_cnt + 4'd1;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : monitor
        sb_t e;
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check({e.tag, "_out"}, 32'(act), 32'(e.o));
            check({e.tag, "_cnt"}, 32'(stall_cnt), 32'(e.cnt));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        in_t idle, start, dstall;
        idle   = vin(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        start  = vin(1, 0, 1, 0, 0, 0, 0, 0, 1, 0);
        dstall = vin(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);

        rst_n = 1'b0;
        drive(start);
        #7;
        check("rst_out", 32'(act), 32'(O_RST));
        check("rst_cnt", 32'(stall_cnt), 32'd0);
        drive(idle);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        apply("idle_a", idle, O_RUN);
        apply("idle_b", idle, O_RUN);
        apply("lu_rs", vin(1, 0, 1, 1, 8, 8, 0, 0, 0, 0), O_LU);
        apply("lu_after", idle, O_RUN);
        apply("lu_rt", vin(1, 0, 1, 1, 9, 3, 9, 1, 0, 0), O_LU);
        apply("rt_nouse", vin(1, 0, 1, 1, 9, 3, 9, 0, 0, 0), O_RUN);
        apply("lu_r0", vin(1, 0, 1, 1, 0, 0, 0, 1, 0, 0), O_RUN);

        apply("mdu_s", start, O_MDU);
        apply("mdu_w1", start, O_MDU);
        apply("mdu_w2", idle, O_MDU);
        apply("mdu_w3", idle, O_MDU);
        apply("mdu_done", idle, O_MDONE);
        apply("mdu_after", idle, O_RUN);

        apply("mdu2_s", start, O_MDU);
        apply("mdu2_w", idle, O_MDU);
        for (int i = 0; i < 3; i++) apply("mdu2_dmem", dstall, O_DMEMB);
        apply("mdu2_r1", idle, O_MDU);
        apply("mdu2_r2", idle, O_MDU);
        apply("mdu2_done", idle, O_MDONE);
        apply("mdu2_after", idle, O_RUN);

        apply("br_lu_imem", vin(0, 0, 1, 1, 8, 8, 0, 0, 0, 1), O_BR);
        apply("br_dmem", vin(1, 1, 0, 0, 0, 0, 0, 0, 0, 1), O_DMEM);
        apply("br_release", vin(1, 1, 1, 0, 0, 0, 0, 0, 0, 1), O_BR);
        apply("imem_a", vin(0, 0, 1, 0, 0, 0, 0, 0, 0, 0), O_IMEM);
        apply("imem_b", vin(0, 0, 1, 0, 0, 0, 0, 0, 0, 0), O_IMEM);
        apply("dmem_mstart", vin(1, 1, 0, 0, 0, 0, 0, 0, 1, 0), O_DMEMB);
        apply("dmem_mheld", idle, O_RUN);
        apply("mdu_br", vin(1, 0, 1, 0, 0, 0, 0, 0, 1, 1), O_MDU);
        apply("mdu3_w1", idle, O_MDU);
        apply("mdu3_w2", idle, O_MDU);
        apply("mdu3_w3", idle, O_MDU);
        apply("mdu3_done", idle, O_MDONE);

        // Abandon an operation with two wait cycles left.
        apply("mdu4_s", start, O_MDU);
        apply("mdu4_w", idle, O_MDU);
        #2;
        rst_n = 1'b0;
        drive(start);
        #1;
        check("midrst_out", 32'(act), 32'(O_RST));
        check("midrst_cnt", 32'(stall_cnt), 32'd0);
        exp_cnt = 4'd0;
        @(posedge clk);
        drive(idle);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        apply("postrst_a", idle, O_RUN);
        apply("postrst_b", idle, O_RUN);
        apply("postrst_c", idle, O_RUN);

        for (int i = 0; i < 17; i++) apply("sat_imem", vin(0, 0, 1, 0, 0, 0, 0, 0, 0, 0), O_IMEM);
        apply("sat_idle", idle, O_RUN);

        @(negedge clk);
        #1;
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
